// File: rtl/cpu_defs_pkg.sv
// cpu_defs: shared opcodes, FSM states, instruction classes and control word
package cpu_defs;
  localparam logic [4:0] OP_LD = 5'd0, OP_LDI = 5'd1, OP_ST = 5'd2, OP_ADD = 5'd3;
  localparam logic [4:0] OP_SUB = 5'd4, OP_AND = 5'd5, OP_OR = 5'd6, OP_SHR = 5'd7;
  localparam logic [4:0] OP_SHRA = 5'd8, OP_SHL = 5'd9, OP_ROR = 5'd10, OP_ROL = 5'd11;
  localparam logic [4:0] OP_ADDI = 5'd12, OP_ANDI = 5'd13, OP_ORI = 5'd14, OP_MUL = 5'd15;
  localparam logic [4:0] OP_DIV = 5'd16, OP_NEG = 5'd17, OP_NOT = 5'd18, OP_BR = 5'd19;
  localparam logic [4:0] OP_JR = 5'd20, OP_JAL = 5'd21, OP_IN = 5'd22, OP_OUT = 5'd23;
  localparam logic [4:0] OP_MFHI = 5'd24, OP_MFLO = 5'd25, OP_NOP = 5'd26, OP_HALT = 5'd27;
  localparam logic [4:0] ALU_ADD = OP_ADD;
  typedef enum logic [3:0] {S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT} state_t;
  typedef enum logic [3:0] {
    C_ALU_R, C_ALU_I, C_LD, C_LDI, C_ST, C_MULDIV, C_UNARY, C_BR,
    C_JR, C_JAL, C_IN, C_OUT, C_MFHI, C_MFLO, C_NOP, C_HALT
  } iclass_t;
  typedef struct packed {
    logic PCout, MDRout, ZHighout, ZLowout, HIout, LOout, InPortout, Cout, BAout, Rout;
    logic MARin, MDRin, PCin, IRin, Yin, Zin, HIin, LOin, Rin, CON_in, OutPortin;
    logic Gra, Grb, Grc, IncPC, Read, Write;
    logic [4:0] opcode;
  } ctrl_t;
  // Final execute step of each class; after it the FSM returns to T0 or halts on stop
  function automatic state_t last_step(iclass_t c);
    case (c)
      C_LD, C_ST: return S_T7;
      C_MULDIV, C_BR: return S_T6;
      C_ALU_R, C_ALU_I, C_LDI: return S_T5;
      C_UNARY, C_JAL: return S_T4;
      default: return S_T3;
    endcase
  endfunction
endpackage

// File: rtl/instr_class_decode.sv
// instr_class_decode: maps an opcode to its instruction class and ALU operation
module instr_class_decode
  import cpu_defs::*;
(
  input  logic [4:0] op,
  output iclass_t    iclass,
  output logic [4:0] alu_op
);
  // Immediate ops borrow the register ALU op; address/branch arithmetic uses ADD
  always_comb begin
    iclass = C_NOP;
    alu_op = ALU_ADD;
    case (op) inside
      [OP_ADD:OP_ROL]: begin iclass = C_ALU_R; alu_op = op; end
      OP_ADDI: begin iclass = C_ALU_I; alu_op = OP_ADD; end
      OP_ANDI: begin iclass = C_ALU_I; alu_op = OP_AND; end
      OP_ORI: begin iclass = C_ALU_I; alu_op = OP_OR; end
      OP_LD: iclass = C_LD;
      OP_LDI: iclass = C_LDI;
      OP_ST: iclass = C_ST;
      OP_MUL, OP_DIV: begin iclass = C_MULDIV; alu_op = op; end
      OP_NEG, OP_NOT: begin iclass = C_UNARY; alu_op = op; end
      OP_BR: iclass = C_BR;
      OP_JR: iclass = C_JR;
      OP_JAL: iclass = C_JAL;
      OP_IN: iclass = C_IN;
      OP_OUT: iclass = C_OUT;
      OP_MFHI: iclass = C_MFHI;
      OP_MFLO: iclass = C_MFLO;
      OP_HALT: iclass = C_HALT;
      default: iclass = C_NOP;
    endcase
  end
endmodule

// File: rtl/control_unit.sv
// control_unit: hardwired fetch/execute sequencer driving the Mini SRC datapath strobes
module control_unit
  import cpu_defs::*;
#(
  parameter int IR_W = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [IR_W-1:0] IR,
  input  logic            CON_FF,
  input  logic            stop,
  output logic            PCout, MDRout, ZHighout, ZLowout, HIout, LOout, InPortout, Cout, BAout, Rout,
  output logic            MARin, MDRin, PCin, IRin, Yin, Zin, HIin, LOin, Rin, CON_in, OutPortin,
  output logic            Gra, Grb, Grc,
  output logic            IncPC, Read, Write,
  output logic [4:0]      opcode,
  output logic            Run
);
  state_t     state;
  iclass_t    iclass;
  logic [4:0] alu_op;
  ctrl_t      c;
  logic       unused_ir;
  assign unused_ir = ^IR[IR_W-6:0];
  instr_class_decode u_dec (.op(IR[IR_W-1 -: 5]), .iclass(iclass), .alu_op(alu_op));
  // Step sequencer: fetch, class-dependent execute length, halt on halt opcode or stop at a boundary
  always_ff @(posedge clk)
    if (!rst) state <= S_RESET;
    else if (state == S_RESET) state <= S_T0;
    else if (state == S_HALT) state <= S_HALT;
    else if (state == S_T2) state <= (iclass == C_HALT) ? S_HALT : S_T3;
    else if (state == last_step(iclass)) state <= stop ? S_HALT : S_T0;
    else state <= state_t'(state + 4'd1);
  // Control word for the current step; anything not set stays deasserted
  always_comb begin
    c = '0;
    case (state)
      S_T0: begin c.PCout = 1; c.MARin = 1; c.IncPC = 1; c.Zin = 1; end
      S_T1: begin c.ZLowout = 1; c.PCin = 1; c.Read = 1; c.MDRin = 1; end
      S_T2: begin c.MDRout = 1; c.IRin = 1; end
      S_T3:
        case (iclass)
          C_ALU_R, C_ALU_I: begin c.Grb = 1; c.Rout = 1; c.Yin = 1; end
          C_LD, C_LDI, C_ST: begin c.Grb = 1; c.BAout = 1; c.Yin = 1; end
          C_MULDIV: begin c.Gra = 1; c.Rout = 1; c.Yin = 1; end
          C_UNARY: begin c.Grb = 1; c.Rout = 1; c.Zin = 1; c.opcode = alu_op; end
          C_BR: begin c.Gra = 1; c.Rout = 1; c.CON_in = 1; end
          C_JR: begin c.Gra = 1; c.Rout = 1; c.PCin = 1; end
          C_JAL: begin c.PCout = 1; c.Grb = 1; c.Rin = 1; end
          C_IN: begin c.InPortout = 1; c.Gra = 1; c.Rin = 1; end
          C_OUT: begin c.Gra = 1; c.Rout = 1; c.OutPortin = 1; end
          C_MFHI: begin c.HIout = 1; c.Gra = 1; c.Rin = 1; end
          C_MFLO: begin c.LOout = 1; c.Gra = 1; c.Rin = 1; end
          default: ;
        endcase
      S_T4:
        case (iclass)
          C_ALU_R: begin c.Grc = 1; c.Rout = 1; c.Zin = 1; c.opcode = alu_op; end
          C_ALU_I, C_LD, C_LDI, C_ST: begin c.Cout = 1; c.Zin = 1; c.opcode = alu_op; end
          C_MULDIV: begin c.Grb = 1; c.Rout = 1; c.Zin = 1; c.opcode = alu_op; end
          C_UNARY: begin c.ZLowout = 1; c.Gra = 1; c.Rin = 1; end
          C_BR: begin c.PCout = 1; c.Yin = 1; end
          C_JAL: begin c.Gra = 1; c.Rout = 1; c.PCin = 1; end
          default: ;
        endcase
      S_T5:
        case (iclass)
          C_ALU_R, C_ALU_I, C_LDI: begin c.ZLowout = 1; c.Gra = 1; c.Rin = 1; end
          C_LD, C_ST: begin c.ZLowout = 1; c.MARin = 1; end
          C_MULDIV: begin c.ZLowout = 1; c.LOin = 1; end
          C_BR: begin c.Cout = 1; c.Zin = 1; c.opcode = ALU_ADD; end
          default: ;
        endcase
      S_T6:
        case (iclass)
          C_LD: begin c.Read = 1; c.MDRin = 1; end
          C_ST: begin c.Gra = 1; c.Rout = 1; c.MDRin = 1; end
          C_MULDIV: begin c.ZHighout = 1; c.HIin = 1; end
          C_BR: begin c.ZLowout = CON_FF; c.PCin = CON_FF; end
          default: ;
        endcase
      S_T7:
        case (iclass)
          C_LD: begin c.MDRout = 1; c.Gra = 1; c.Rin = 1; end
          C_ST: c.Write = 1;
          default: ;
        endcase
      default: ;
    endcase
  end
  assign {PCout, MDRout, ZHighout, ZLowout, HIout, LOout, InPortout, Cout, BAout, Rout,
          MARin, MDRin, PCin, IRin, Yin, Zin, HIin, LOin, Rin, CON_in, OutPortin,
          Gra, Grb, Grc, IncPC, Read, Write, opcode} = c;
  assign Run = (state != S_RESET) && (state != S_HALT);
endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: randomized instruction streams checked against a per-instruction step table
module tb_control_unit;
  logic clk, rst, CON_FF, stop;
  logic [31:0] IR;
  logic PCout, MDRout, ZHighout, ZLowout, HIout, LOout, InPortout, Cout, BAout, Rout;
  logic MARin, MDRin, PCin, IRin, Yin, Zin, HIin, LOin, Rin, CON_in, OutPortin;
  logic Gra, Grb, Grc, IncPC, Read, Write, Run;
  logic [4:0] opcode;
  logic [26:0] obs;
  int checks = 0, passed = 0;
  int exp_n;
  logic [26:0] exp_m [8];
  logic [4:0] exp_o [8];

  localparam logic [26:0] PCO = 27'h1 << 26, MDRO = 27'h1 << 25, ZHO = 27'h1 << 24, ZLO = 27'h1 << 23;
  localparam logic [26:0] HIO = 27'h1 << 22, LOO = 27'h1 << 21, INP = 27'h1 << 20, CO = 27'h1 << 19;
  localparam logic [26:0] BAO = 27'h1 << 18, RO = 27'h1 << 17, MARI = 27'h1 << 16, MDRI = 27'h1 << 15;
  localparam logic [26:0] PCI = 27'h1 << 14, IRI = 27'h1 << 13, YI = 27'h1 << 12, ZI = 27'h1 << 11;
  localparam logic [26:0] HII = 27'h1 << 10, LOI = 27'h1 << 9, RI = 27'h1 << 8, CONI = 27'h1 << 7;
  localparam logic [26:0] OUTI = 27'h1 << 6, GRA = 27'h1 << 5, GRB = 27'h1 << 4, GRC = 27'h1 << 3;
  localparam logic [26:0] INC = 27'h1 << 2, RD = 27'h1 << 1, WR = 27'h1;

  control_unit #(.IR_W(32)) dut (
    .clk(clk), .rst(rst), .IR(IR), .CON_FF(CON_FF), .stop(stop),
    .PCout(PCout), .MDRout(MDRout), .ZHighout(ZHighout), .ZLowout(ZLowout), .HIout(HIout),
    .LOout(LOout), .InPortout(InPortout), .Cout(Cout), .BAout(BAout), .Rout(Rout),
    .MARin(MARin), .MDRin(MDRin), .PCin(PCin), .IRin(IRin), .Yin(Yin), .Zin(Zin),
    .HIin(HIin), .LOin(LOin), .Rin(Rin), .CON_in(CON_in), .OutPortin(OutPortin),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .IncPC(IncPC), .Read(Read), .Write(Write),
    .opcode(opcode), .Run(Run)
  );

  assign obs = {PCout, MDRout, ZHighout, ZLowout, HIout, LOout, InPortout, Cout, BAout, Rout,
                MARin, MDRin, PCin, IRin, Yin, Zin, HIin, LOin, Rin, CON_in, OutPortin,
                Gra, Grb, Grc, IncPC, Read, Write};

  initial clk = 0;
  always #5 clk = ~clk;

  // Expected strobe table for one instruction, straight from the instruction descriptions
  task automatic build(input logic [4:0] op, input logic con);
    for (int k = 0; k < 8; k++) begin exp_m[k] = '0; exp_o[k] = '0; end
    exp_m[0] = PCO | MARI | INC | ZI;
    exp_m[1] = ZLO | PCI | RD | MDRI;
    exp_m[2] = MDRO | IRI;
    exp_n = 4;
    if (op >= 3 && op <= 14) begin
      exp_n = 6;
      exp_m[3] = GRB | RO | YI;
      exp_m[4] = (op <= 11) ? (GRC | RO | ZI) : (CO | ZI);
      exp_o[4] = (op <= 11) ? op : (op == 12) ? 5'd3 : (op == 13) ? 5'd5 : 5'd6;
      exp_m[5] = ZLO | GRA | RI;
    end else if (op <= 2) begin
      exp_n = (op == 1) ? 6 : 8;
      exp_m[3] = GRB | BAO | YI;
      exp_m[4] = CO | ZI;
      exp_o[4] = 5'd3;
      exp_m[5] = (op == 1) ? (ZLO | GRA | RI) : (ZLO | MARI);
      exp_m[6] = (op == 0) ? (RD | MDRI) : (GRA | RO | MDRI);
      exp_m[7] = (op == 0) ? (MDRO | GRA | RI) : WR;
    end else
      case (op)
        15, 16: begin exp_n = 7; exp_m[3] = GRA | RO | YI; exp_m[4] = GRB | RO | ZI; exp_o[4] = op;
                      exp_m[5] = ZLO | LOI; exp_m[6] = ZHO | HII; end
        17, 18: begin exp_n = 5; exp_m[3] = GRB | RO | ZI; exp_o[3] = op; exp_m[4] = ZLO | GRA | RI; end
        19: begin exp_n = 7; exp_m[3] = GRA | RO | CONI; exp_m[4] = PCO | YI; exp_m[5] = CO | ZI;
                  exp_o[5] = 5'd3; exp_m[6] = con ? (ZLO | PCI) : '0; end
        20: exp_m[3] = GRA | RO | PCI;
        21: begin exp_n = 5; exp_m[3] = PCO | GRB | RI; exp_m[4] = GRA | RO | PCI; end
        22: exp_m[3] = INP | GRA | RI;
        23: exp_m[3] = GRA | RO | OUTI;
        24: exp_m[3] = HIO | GRA | RI;
        25: exp_m[3] = LOO | GRA | RI;
        27: exp_n = 3;
        default: ;
      endcase
  endtask

  // Runs one instruction from T0; optionally stops at the final step or resets at step abort_at
  task automatic exec(input string name, input logic [31:0] ir, input logic con, input logic stop_last, input int abort_at);
    logic [4:0] op;
    op = ir[31:27];
    build(op, con);
    IR = ir;
    for (int k = 0; k < exp_n; k++) begin
      stop = (k == exp_n - 1) ? stop_last : 1'($urandom);
      CON_FF = (op == 5'd19 && k == 6) ? con : 1'($urandom);
      rst = (k == abort_at) ? 1'b0 : 1'b1;
      @(negedge clk);
      checks += 3;
      if (obs !== exp_m[k]) $display("FAIL %s step T%0d strobes got %b want %b", name, k, obs, exp_m[k]);
      else passed++;
      if (opcode !== exp_o[k]) $display("FAIL %s step T%0d opcode got %b want %b", name, k, opcode, exp_o[k]);
      else passed++;
      if (Run !== 1'b1) $display("FAIL %s step T%0d run got %b want 1", name, k, Run);
      else passed++;
      @(posedge clk); #1;
      if (k == abort_at) break;
    end
    rst = 1;
    stop = 0;
    if (abort_at >= 0) begin
      @(negedge clk);
      checks += 2;
      if ({obs, opcode} !== '0) $display("FAIL %s reset_state outputs got %b want 0", name, {obs, opcode});
      else passed++;
      if (Run !== 1'b0) $display("FAIL %s reset_state run got %b want 0", name, Run);
      else passed++;
      @(posedge clk); #1;
    end else if (stop_last || op == 5'd27) begin
      repeat (20) begin
        stop = 1'($urandom);
        IR = $urandom;
        CON_FF = 1'($urandom);
        @(negedge clk);
        checks += 2;
        if ({obs, opcode} !== '0) $display("FAIL %s halt outputs got %b want 0", name, {obs, opcode});
        else passed++;
        if (Run !== 1'b0) $display("FAIL %s halt run got %b want 0", name, Run);
        else passed++;
        @(posedge clk); #1;
      end
      test_reset();
    end
  endtask

  task automatic test_reset();
    rst = 0;
    repeat (2) begin
      @(posedge clk); #1;
      @(negedge clk);
      checks += 2;
      if ({obs, opcode} !== '0) $display("FAIL reset outputs got %b want 0", {obs, opcode});
      else passed++;
      if (Run !== 1'b0) $display("FAIL reset run got %b want 0", Run);
      else passed++;
    end
    rst = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_load();
    exec("ld", 32'h03000002, 1'b0, 1'b0, -1);
    exec("ldi", {5'd1, 27'($urandom)}, 1'b0, 1'b0, -1);
  endtask

  task automatic test_branch();
    exec("br_taken", 32'h9B000019, 1'b1, 1'b0, -1);
    exec("br_not_taken", 32'h9B000019, 1'b0, 1'b0, -1);
    exec("after_br", {5'd26, 27'($urandom)}, 1'b0, 1'b0, -1);
  endtask

  task automatic test_alu();
    for (int op = 3; op <= 18; op++) exec("alu", {5'(op), 27'($urandom)}, 1'b0, 1'b0, -1);
  endtask

  task automatic test_store();
    exec("st", {5'd2, 27'($urandom)}, 1'b0, 1'b0, -1);
    exec("after_st", {5'd22, 27'($urandom)}, 1'b0, 1'b0, -1);
  endtask

  task automatic test_reset_mid();
    exec("ld_abort", {5'd0, 27'($urandom)}, 1'b0, 1'b0, 5);
    exec("after_abort", {5'd23, 27'($urandom)}, 1'b0, 1'b0, -1);
  endtask

  task automatic test_back_to_back();
    logic [4:0] op;
    repeat (60) begin
      op = 5'($urandom_range(0, 31));
      if (op == 5'd27) op = 5'd26;
      exec("random", {op, 27'($urandom)}, 1'($urandom), 1'b0, -1);
    end
  endtask

  task automatic test_halt();
    exec("halt_op", {5'd27, 27'($urandom)}, 1'b0, 1'b0, -1);
    exec("stop_add", {5'd3, 27'($urandom)}, 1'b0, 1'b1, -1);
    exec("stop_jal", {5'd21, 27'($urandom)}, 1'b0, 1'b1, -1);
    exec("after_halt", {5'd0, 27'($urandom)}, 1'b0, 1'b0, -1);
  endtask

  initial begin
    rst = 0; IR = 0; CON_FF = 0; stop = 0;
    test_reset();
    test_load();
    test_branch();
    test_alu();
    test_store();
    test_reset_mid();
    test_back_to_back();
    test_halt();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
